param_register_file: RTL

- Parametrised general-purpose register file for the multicycle CPU datapath. Next generation of the fixed 32x32 register bank.
- Configurable data width and depth, with an optional hardwired-zero entry 0.
- Clear-all is a sequenced one-entry-per-cycle sweep with a busy indication, not a single-edge wipe.
- Two combinational read ports and one synchronous write port feed the ALU operand latches; the write port is driven from the writeback stage.

---
 rtl/param_register_file.sv | 134 +++++++++++++
 1 files changed

// File: rtl/param_register_file.sv
// param_register_file: parametrised general-purpose register file.
// Two combinational read ports and one synchronous write port. Clear-all runs
// as a one-entry-per-cycle sweep and raises Busy while it is in progress.
// Optional build macro: REGFILE_BYPASS_EN enables write-to-read forwarding.
module param_register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 1
) (
   input  logic                  Clock,
   input  logic                  ResetN,
   input  logic [ADDR_WIDTH-1:0] ReadReg1Address,
   input  logic [ADDR_WIDTH-1:0] ReadReg2Address,
   input  logic [ADDR_WIDTH-1:0] WriteRegAddress,
   input  logic [DATA_WIDTH-1:0] DataOfWrite,
   input  logic                  WriteControl,
   input  logic                  CleanAllControl,
   output logic [DATA_WIDTH-1:0] ReadData1,
   output logic [DATA_WIDTH-1:0] ReadData2,
   output logic                  Busy,
   output logic                  WriteDropped
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   // Entry 0 is skipped by the sweep when it is hardwired to zero.
   localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = (ZERO_REG != 0) ? ADDR_WIDTH'(1) : '0;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } stateT;

   stateT                  state;
   stateT                  nextState;
   logic [ADDR_WIDTH-1:0]  clearIdx;
   logic [DATA_WIDTH-1:0]  regArray [DEPTH];
   logic                   busyReg;
   logic                   droppedReg;
   logic                   writeCommit;

   // True when the address names the hardwired-zero entry.
   function automatic logic isZeroEntry(input logic [ADDR_WIDTH-1:0] addr);
      return (ZERO_REG != 0) && (addr == '0);
   endfunction

   // Writes only land while idle; entry 0 writes vanish silently when hardwired.
   assign writeCommit = WriteControl && (state == IDLE) && !isZeroEntry(WriteRegAddress);

   // State register; reset aborts any sweep in progress.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state: start on a clear request, finish on the edge that clears the last entry.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (CleanAllControl) nextState = CLEAR;
         CLEAR:   if (clearIdx == LAST_IDX) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Sweep index: loads the first clearable entry on entry to CLEAR, then advances.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         clearIdx <= FIRST_IDX;
      end else if (state == IDLE) begin
         clearIdx <= FIRST_IDX;
      end else if (clearIdx != LAST_IDX) begin
         clearIdx <= clearIdx + ADDR_WIDTH'(1);
      end else begin
         clearIdx <= FIRST_IDX;
      end
   end

   // Busy and the dropped-write pulse are both registered status flags.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         busyReg    <= 1'b0;
         droppedReg <= 1'b0;
      end else begin
         busyReg    <= (nextState == CLEAR);
         droppedReg <= WriteControl && (state == CLEAR);
      end
   end

   assign Busy         = busyReg;
   assign WriteDropped = droppedReg;

   // Storage: normal writes while idle, one entry zeroed per cycle while clearing.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         for (int i = 0; i < DEPTH; i++) begin
            regArray[i] <= '0;
         end
      end else if (state == CLEAR) begin
         regArray[clearIdx] <= '0;
      end else if (writeCommit) begin
         regArray[WriteRegAddress] <= DataOfWrite;
      end
   end

`ifdef REGFILE_BYPASS_EN
   logic fwd1;
   logic fwd2;

   // A write that will commit this edge is forwarded straight to a matching read port.
   assign fwd1 = WriteControl && !busyReg && (ReadReg1Address == WriteRegAddress)
                 && !isZeroEntry(ReadReg1Address);
   assign fwd2 = WriteControl && !busyReg && (ReadReg2Address == WriteRegAddress)
                 && !isZeroEntry(ReadReg2Address);

   // Read ports with forwarding of the in-flight write.
   always_comb begin
      ReadData1 = isZeroEntry(ReadReg1Address) ? '0 : regArray[ReadReg1Address];
      ReadData2 = isZeroEntry(ReadReg2Address) ? '0 : regArray[ReadReg2Address];
      if (fwd1) ReadData1 = DataOfWrite;
      if (fwd2) ReadData2 = DataOfWrite;
   end
`else
   // Read ports show committed array contents only.
   always_comb begin
      ReadData1 = isZeroEntry(ReadReg1Address) ? '0 : regArray[ReadReg1Address];
      ReadData2 = isZeroEntry(ReadReg2Address) ? '0 : regArray[ReadReg2Address];
   end
`endif

endmodule
